// File: rtl/ccff_loader_pkg.sv
// ccff_loader_pkg
// Shared types and constants for the CCFF bitstream loader.
//   - state_e      : loader FSM states
//   - CRC_POLY/INIT: CRC-16-CCITT constants (used when CCFF_CRC_EN is defined)
//   - crc_words()  : number of bitstream words that carry the 16-bit expected CRC
//   - crc16_step() : one serial CRC update step (MSB-first, no reflection)
package ccff_loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    // ceil(16 / word_w): words needed to carry the expected CRC
    function automatic int crc_words(input int word_w);
        return (16 + word_w - 1) / word_w;
    endfunction

    // Serial CRC-16 update: feedback is the outgoing MSB xor the incoming bit
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
        logic fb;
        fb = crc[15] ^ din;
        return {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/ccff_loader_crc16_serial.sv
// ccff_crc16_serial
// Bit-serial CRC-16-CCITT accumulator, one bit per enabled prog_clk cycle.
// Ports:
//   prog_clk : clock
//   pReset   : asynchronous active-low reset (loads CRC_INIT)
//   clr      : synchronous re-initialise to CRC_INIT (has priority over en)
//   en       : consume din this cycle
//   din      : serial data bit
//   crc      : current CRC register
module ccff_crc16_serial
    import ccff_loader_pkg::*;
(
    input  logic        prog_clk,
    input  logic        pReset,
    input  logic        clr,
    input  logic        en,
    input  logic        din,
    output logic [15:0] crc
);

    logic [15:0] crc_r;

    // CRC register: init on reset/clear, one step per enabled bit
    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            crc_r <= CRC_INIT;
        end else if (clr) begin
            crc_r <= CRC_INIT;
        end else if (en) begin
            crc_r <= crc16_step(crc_r, din);
        end else begin
            crc_r <= crc_r;
        end
    end

    assign crc = crc_r;

endmodule

// File: rtl/ccff_bitstream_loader.sv
// ccff_bitstream_loader
// Feeds the CCFF configuration scan chain: accepts bitstream words over
// valid/ready, serialises them MSB-first onto ccff_head with a per-bit
// ccff_shift_en, and stops after exactly CHAIN_LEN bits.
// Optional feature macro: CCFF_CRC_EN -- adds a CHECK state that receives the
// expected CRC-16-CCITT after the load and flags a mismatch on err.
// Ports:
//   prog_clk      : programming clock
//   pReset        : asynchronous active-low reset
//   start         : pulse that begins a load (ignored while busy)
//   bs_data       : bitstream word, bit WORD_W-1 shifted first
//   bs_valid      : bs_data valid
//   bs_ready      : loader accepts the word this cycle
//   ccff_head     : serial configuration bit into the chain
//   ccff_shift_en : chain clock enable
//   busy          : load (or CRC check) in progress
//   done          : load complete, held until next accepted start
//   err           : CRC mismatch, held until next accepted start (0 without CCFF_CRC_EN)
//   bit_count     : bits shifted so far in the current load
module ccff_bitstream_loader
    import ccff_loader_pkg::*;
#(
    parameter int WORD_W    = 8,
    parameter int CHAIN_LEN = 30,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic [WORD_W-1:0] bs_data,
    input  logic              bs_valid,
    output logic              bs_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CNT_W-1:0]  bit_count
);

    localparam int REM_W = $clog2(WORD_W + 1);

    state_e              state_r;
    logic [WORD_W-1:0]   word_r;        // bits not yet placed on ccff_head, MSB next
    logic [REM_W-1:0]    rem_r;         // number of valid bits left in word_r
    logic [CNT_W-1:0]    bit_count_r;
    logic                ccff_head_r;
    logic                shift_en_r;
    logic                bs_ready_r;
    logic                busy_r;
    logic                done_r;

    logic                take_s;
    logic                start_ok_s;
    logic                launch_s;
    logic                launch_bit_s;
    logic [WORD_W-1:0]   word_nxt_s;
    logic [REM_W-1:0]    rem_nxt_s;
    logic [CNT_W-1:0]    count_nxt_s;
    logic                ready_nxt_s;

    // bs_ready_r is kept equal to the ready condition, so it alone qualifies the handshake
    assign take_s     = bs_valid & bs_ready_r;
    assign start_ok_s = start & ((state_r == IDLE) | (state_r == DONE));

    // Next bit to put on ccff_head. Once word_r is drained, a word taken at this edge
    // launches its MSB immediately, which keeps consecutive words bubble-free.
    always_comb begin
        launch_s     = 1'b0;
        launch_bit_s = ccff_head_r;
        word_nxt_s   = word_r;
        rem_nxt_s    = rem_r;
        if ((state_r == LOAD) && (bit_count_r < CNT_W'(CHAIN_LEN))) begin
            if (rem_r != REM_W'(0)) begin
                launch_s     = 1'b1;
                launch_bit_s = word_r[WORD_W-1];
                word_nxt_s   = word_r << 1'b1;
                rem_nxt_s    = rem_r - REM_W'(1);
            end else if (take_s) begin
                launch_s     = 1'b1;
                launch_bit_s = bs_data[WORD_W-1];
                word_nxt_s   = bs_data << 1'b1;
                rem_nxt_s    = REM_W'(WORD_W - 1);
            end else begin
                launch_s     = 1'b0;
            end
        end else begin
            launch_s = 1'b0;
        end
        count_nxt_s = launch_s ? (bit_count_r + CNT_W'(1)) : bit_count_r;
        // Ready again once the register drains, unless the terminal bit is already out
        ready_nxt_s = (rem_nxt_s == REM_W'(0)) && (count_nxt_s < CNT_W'(CHAIN_LEN));
    end

`ifdef CCFF_CRC_EN
    localparam int CRC_WORDS = crc_words(WORD_W);
    localparam int ACC_W     = CRC_WORDS * WORD_W;
    localparam int CHK_W     = $clog2(CRC_WORDS + 1);

    logic [15:0]       crc_s;
    logic [ACC_W-1:0]  acc_r;
    logic [ACC_W-1:0]  acc_nxt_s;
    logic [15:0]       exp_crc_s;
    logic [CHK_W-1:0]  chk_cnt_r;
    logic              err_r;

    // Expected CRC arrives MSB-first; surplus low bits of the last word fall off the bottom
    assign acc_nxt_s = (acc_r << WORD_W) | ACC_W'(bs_data);
    assign exp_crc_s = acc_nxt_s[ACC_W-1 -: 16];

    ccff_crc16_serial u_crc (
        .prog_clk (prog_clk),
        .pReset   (pReset),
        .clr      (start_ok_s),
        .en       (launch_s),
        .din      (launch_bit_s),
        .crc      (crc_s)
    );
`endif

    // Loader FSM with all outputs registered
    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            state_r     <= IDLE;
            word_r      <= '0;
            rem_r       <= '0;
            bit_count_r <= '0;
            ccff_head_r <= 1'b0;
            shift_en_r  <= 1'b0;
            bs_ready_r  <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
`ifdef CCFF_CRC_EN
            acc_r       <= '0;
            chk_cnt_r   <= '0;
            err_r       <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    shift_en_r <= 1'b0;
                    if (start_ok_s) begin
                        state_r     <= LOAD;
                        rem_r       <= '0;
                        bit_count_r <= '0;
                        bs_ready_r  <= 1'b1;
                        busy_r      <= 1'b1;
                        done_r      <= 1'b0;
`ifdef CCFF_CRC_EN
                        err_r       <= 1'b0;
`endif
                    end else begin
                        bs_ready_r <= 1'b0;
                    end
                end
                LOAD: begin
                    if (bit_count_r == CNT_W'(CHAIN_LEN)) begin
                        // Terminal bit has been shifted: discard leftovers
                        shift_en_r <= 1'b0;
                        rem_r      <= '0;
`ifdef CCFF_CRC_EN
                        state_r    <= CHECK;
                        bs_ready_r <= 1'b1;
                        chk_cnt_r  <= '0;
`else
                        state_r    <= DONE;
                        bs_ready_r <= 1'b0;
                        busy_r     <= 1'b0;
                        done_r     <= 1'b1;
`endif
                    end else begin
                        shift_en_r  <= launch_s;
                        ccff_head_r <= launch_bit_s;
                        word_r      <= word_nxt_s;
                        rem_r       <= rem_nxt_s;
                        bit_count_r <= count_nxt_s;
                        bs_ready_r  <= ready_nxt_s;
                    end
                end
                CHECK: begin
                    shift_en_r <= 1'b0;
`ifdef CCFF_CRC_EN
                    if (take_s) begin
                        acc_r <= acc_nxt_s;
                        if (chk_cnt_r == CHK_W'(CRC_WORDS - 1)) begin
                            err_r      <= (exp_crc_s != crc_s);
                            state_r    <= DONE;
                            bs_ready_r <= 1'b0;
                            busy_r     <= 1'b0;
                            done_r     <= 1'b1;
                        end else begin
                            chk_cnt_r <= chk_cnt_r + CHK_W'(1);
                        end
                    end else begin
                        acc_r <= acc_r;
                    end
`else
                    state_r    <= IDLE;
                    bs_ready_r <= 1'b0;
                    busy_r     <= 1'b0;
`endif
                end
                default: begin
                    state_r    <= IDLE;
                    shift_en_r <= 1'b0;
                    bs_ready_r <= 1'b0;
                    busy_r     <= 1'b0;
                end
            endcase
        end
    end

    assign bs_ready      = bs_ready_r;
    assign ccff_head     = ccff_head_r;
    assign ccff_shift_en = shift_en_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign bit_count     = bit_count_r;
`ifdef CCFF_CRC_EN
    assign err           = err_r;
`else
    assign err           = 1'b0;
`endif

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Testbench for ccff_bitstream_loader (WORD_W=8, CHAIN_LEN=30).
// Expected chain bits and end-of-load results are queued when stimulus is
// issued; a monitor on the falling clock edge pops and compares them.
// With CCFF_CRC_EN defined the CRC check/mismatch scenarios are added.
module tb_ccff_bitstream_loader;

    logic       prog_clk;
    logic       pReset;
    logic       start;
    logic [7:0] bs_data;
    logic       bs_valid;
    logic       bs_ready;
    logic       ccff_head;
    logic       ccff_shift_en;
    logic       busy;
    logic       done;
    logic       err;
    logic [4:0] bit_count;

    ccff_bitstream_loader #(.WORD_W(8), .CHAIN_LEN(30)) dut (
        .prog_clk      (prog_clk),
        .pReset        (pReset),
        .start         (start),
        .bs_data       (bs_data),
        .bs_valid      (bs_valid),
        .bs_ready      (bs_ready),
        .ccff_head     (ccff_head),
        .ccff_shift_en (ccff_shift_en),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .bit_count     (bit_count)
    );

    initial prog_clk = 1'b0;
    always #5 prog_clk = ~prog_clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // Scoreboards
    bit exp_bits_q[$];
    int exp_cnt_q[$];
    bit exp_err_q[$];
    int shifts_seen = 0;
    bit prev_last   = 1'b0;
    bit done_prev   = 1'b0;

    // Hand-derived: A5, 3C, FF, then top 6 bits of 81
    logic [29:0] golden_bits = 30'b10100101_00111100_11111111_100000;
    logic [7:0]  words [4]   = '{8'hA5, 8'h3C, 8'hFF, 8'h81};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: compares every shifted bit and the end-of-load state
    always @(negedge prog_clk) begin
        if (pReset) begin
            if (prev_last) begin
`ifdef CCFF_CRC_EN
                check("enter_check_busy", {31'd0, busy}, 32'd1);
                check("enter_check_ready", {31'd0, bs_ready}, 32'd1);
`else
                check("done_after_last", {31'd0, done}, 32'd1);
                check("ready_after_last", {31'd0, bs_ready}, 32'd0);
`endif
                check("no_shift_after_last", {31'd0, ccff_shift_en}, 32'd0);
            end
            prev_last = 1'b0;
            if (ccff_shift_en) begin
                shifts_seen++;
                if (exp_bits_q.size() == 0) begin
                    check("spurious_shift", 32'd1, 32'd0);
                end else begin
                    check("ccff_head", {31'd0, ccff_head}, {31'd0, exp_bits_q.pop_front()});
                end
                if (shifts_seen == 30) prev_last = 1'b1;
            end
            if (done && !done_prev) begin
                if (exp_cnt_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    check("bit_count_at_done", {27'd0, bit_count}, exp_cnt_q.pop_front());
                    check("err_at_done", {31'd0, err}, {31'd0, exp_err_q.pop_front()});
                    check("shifts_at_done", shifts_seen, 32'd30);
                end
            end
            done_prev = done;
        end else begin
            prev_last = 1'b0;
            done_prev = 1'b0;
        end
    end

    task automatic start_load(input bit exp_err);
        shifts_seen = 0;
        for (int i = 29; i >= 0; i--) exp_bits_q.push_back(golden_bits[i]);
        exp_cnt_q.push_back(30);
        exp_err_q.push_back(exp_err);
        start = 1'b1;
        @(posedge prog_clk); #1;
        start = 1'b0;
        check("start_busy", {31'd0, busy}, 32'd1);
        check("start_done_clr", {31'd0, done}, 32'd0);
        check("start_err_clr", {31'd0, err}, 32'd0);
        check("start_count_clr", {27'd0, bit_count}, 32'd0);
    endtask

    task automatic send_word(input logic [7:0] w);
        bit ok;
        ok = 1'b0;
        bs_data  = w;
        bs_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge prog_clk);
            if (bs_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            @(posedge prog_clk); #1;
        end else begin
            check("handshake_timeout", 32'd0, 32'd1);
            bs_valid = 1'b0;
        end
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge prog_clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("done_timeout", 32'd0, 32'd1);
        @(posedge prog_clk); #1;
    endtask

`ifdef CCFF_CRC_EN
    // Reference CRC by polynomial long division (init folded into the top 16 bits)
    function automatic logic [15:0] ref_crc(input logic [29:0] m);
        logic [45:0] v;
        v = {m ^ {16'hFFFF, 14'd0}, 16'h0000};
        for (int i = 45; i >= 16; i--) begin
            if (v[i]) v = v ^ ({29'd0, 17'h11021} << (i - 16));
        end
        return v[15:0];
    endfunction
`endif

    initial begin
        bit          moved;
        logic        h;
        logic [15:0] crc;

        pReset   = 1'b1;
        start    = 1'b0;
        bs_valid = 1'b0;
        bs_data  = 8'h00;
        #3 pReset = 1'b0;
        #1;
        check("rst_count", {27'd0, bit_count}, 32'd0);
        check("rst_head", {31'd0, ccff_head}, 32'd0);
        check("rst_shift_en", {31'd0, ccff_shift_en}, 32'd0);
        check("rst_ready", {31'd0, bs_ready}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        #18 pReset = 1'b1;
        @(posedge prog_clk); #1;

        // valid in IDLE is ignored
        bs_data = 8'h5A; bs_valid = 1'b1;
        repeat (3) @(posedge prog_clk);
        #1;
        check("idle_ready", {31'd0, bs_ready}, 32'd0);
        bs_valid = 1'b0;

        // Basic back-to-back load
        start_load(1'b0);
        for (int i = 0; i < 4; i++) send_word(words[i]);
        bs_valid = 1'b0;
        wait_done();
        check("basic_count", {27'd0, bit_count}, 32'd30);
        // Extra word after done must not be consumed
        bs_data = 8'h55; bs_valid = 1'b1;
        moved = 1'b0;
        repeat (4) begin
            @(negedge prog_clk);
            if (bs_ready || ccff_shift_en) moved = 1'b1;
        end
        check("done_no_accept", {31'd0, moved}, 32'd0);
        bs_valid = 1'b0;
        @(posedge prog_clk); #1;

        // Starvation gap after word 2
        start_load(1'b0);
        send_word(words[0]);
        send_word(words[1]);
        bs_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge prog_clk);
            if (!ccff_shift_en) break;
        end
        h = ccff_head;
        moved = 1'b0;
        repeat (5) begin
            @(negedge prog_clk);
            if (ccff_shift_en || ccff_head !== h) moved = 1'b1;
        end
        check("starve_hold", {31'd0, moved}, 32'd0);
        check("starve_count", {27'd0, bit_count}, 32'd16);
        @(posedge prog_clk); #1;
        send_word(words[2]);
        send_word(words[3]);
        bs_valid = 1'b0;
        wait_done();

        // start while busy is ignored
        start_load(1'b0);
        send_word(words[0]);
        send_word(words[1]);
        bs_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge prog_clk);
            if (bit_count == 5'd12) break;
        end
        check("mid_count", {27'd0, bit_count}, 32'd12);
        start = 1'b1;
        @(posedge prog_clk); #1;
        start = 1'b0;
        check("mid_start_busy", {31'd0, busy}, 32'd1);
        send_word(words[2]);
        send_word(words[3]);
        bs_valid = 1'b0;
        wait_done();

        // Reset mid-load at bit 17, then a clean reload
        start_load(1'b0);
        send_word(words[0]);
        send_word(words[1]);
        send_word(words[2]);
        bs_valid = 1'b0;
        check("pre_rst_count", {27'd0, bit_count}, 32'd17);
        pReset = 1'b0;
        #1;
        check("arst_count", {27'd0, bit_count}, 32'd0);
        check("arst_head", {31'd0, ccff_head}, 32'd0);
        check("arst_shift_en", {31'd0, ccff_shift_en}, 32'd0);
        check("arst_ready", {31'd0, bs_ready}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        exp_bits_q.delete();
        exp_cnt_q.delete();
        exp_err_q.delete();
        repeat (2) @(posedge prog_clk);
        #1 pReset = 1'b1;
        @(posedge prog_clk); #1;
        start_load(1'b0);
        for (int i = 0; i < 4; i++) send_word(words[i]);
        bs_valid = 1'b0;
        wait_done();

`ifdef CCFF_CRC_EN
        crc = ref_crc(golden_bits);
        // Matching CRC
        start_load(1'b0);
        for (int i = 0; i < 4; i++) send_word(words[i]);
        send_word(crc[15:8]);
        send_word(crc[7:0]);
        bs_valid = 1'b0;
        wait_done();
        // Mismatching CRC (LSB flipped)
        start_load(1'b1);
        for (int i = 0; i < 4; i++) send_word(words[i]);
        send_word(crc[15:8]);
        send_word(crc[7:0] ^ 8'h01);
        bs_valid = 1'b0;
        wait_done();
        check("crc_err_held", {31'd0, err}, 32'd1);
        // err clears on the next start (checked in start_load)
        start_load(1'b0);
        for (int i = 0; i < 4; i++) send_word(words[i]);
        send_word(crc[15:8]);
        send_word(crc[7:0]);
        bs_valid = 1'b0;
        wait_done();
`else
        crc = 16'h0000;
        check("no_crc_err", {31'd0, err}, {16'd0, crc});
`endif

        check("queue_drained", exp_bits_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
